// File: rtl/hyperbus_rx_pkg.sv
// Shared types for the HyperBus receive framing path.
package hyperbus_rx_pkg;

  localparam int unsigned RX_WORD_W = 16;

  typedef logic [RX_WORD_W-1:0] rx_word_t;

  typedef enum logic [1:0] {
    SKIP   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } rx_state_e;

endpackage

// File: rtl/hyperbus_rx_edge_cnt.sv
// Up-counter with async active-high clear; stops at the compare limit or all-ones.
module hyperbus_rx_edge_cnt #(
  parameter int unsigned W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);

  logic [W-1:0] cnt_q;

  assign term_o = (cnt_q == limit_i);
  assign cnt_o  = cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (en_i && !term_o && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/hyperbus_rx_framer.sv
// RWDS-domain read framer: drops leading edges, forwards burst_len words, then a flush edge.
module hyperbus_rx_framer
  import hyperbus_rx_pkg::*;
#(
  parameter int unsigned LEN_W  = 10,
  parameter int unsigned SKIP_W = 2
) (
  input  logic              clk_rwds,
  input  logic              resetReadModule,
  input  logic [LEN_W-1:0]  burst_len_i,
  input  logic [SKIP_W-1:0] skip_i,
  input  rx_word_t          data_i,
  input  logic              fifo_ready_i,
  output logic              valid_o,
  output rx_word_t          data_o,
  output logic              last_o,
  output logic [LEN_W-1:0]  word_cnt_o,
  output logic              overflow_o,
  output logic              extra_o
);

  rx_state_e state_q, state_d, eff_state;
  logic      valid_q, valid_d;
  rx_word_t  data_q, data_d;
  logic      last_q, last_d;
  logic      overflow_q, overflow_d;
  logic      extra_q, extra_d;

  logic              skip_en, skip_term;
  logic [SKIP_W-1:0] skip_cnt_unused;
  logic              word_en, word_term;
  logic [LEN_W-1:0]  word_cnt;
  logic [LEN_W:0]    word_plus1;
  logic              is_last;

  hyperbus_rx_edge_cnt #(.W(SKIP_W)) u_skip_cnt (
    .clk_i   (clk_rwds),
    .rst_i   (resetReadModule),
    .en_i    (skip_en),
    .limit_i (skip_i),
    .cnt_o   (skip_cnt_unused),
    .term_o  (skip_term)
  );

  hyperbus_rx_edge_cnt #(.W(LEN_W)) u_word_cnt (
    .clk_i   (clk_rwds),
    .rst_i   (resetReadModule),
    .en_i    (word_en),
    .limit_i (burst_len_i),
    .cnt_o   (word_cnt),
    .term_o  (word_term)
  );

  assign word_plus1 = {1'b0, word_cnt} + 1'b1;
  assign is_last    = (word_plus1 == {1'b0, burst_len_i});

  // Reaching the skip target behaves as the following state on the same edge,
  // so skip_i=0 streams (or flushes, for a zero-length burst) from the first edge.
  always_comb begin
    eff_state = state_q;
    if (state_q == SKIP && skip_term) begin
      eff_state = (burst_len_i == '0) ? FLUSH : STREAM;
    end
  end

  always_comb begin
    state_d    = eff_state;
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;
    overflow_d = overflow_q | (valid_q & ~fifo_ready_i);
    extra_d    = extra_q;
    skip_en    = 1'b0;
    word_en    = 1'b0;
    case (eff_state)
      SKIP: begin
        skip_en = 1'b1;
      end
      STREAM: begin
        if (word_term) begin
          // Burst already complete (length lowered mid-burst): treat as flush edge.
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = DONE;
        end else begin
          data_d  = data_i;
          valid_d = 1'b1;
          word_en = 1'b1;
          last_d  = is_last;
          state_d = is_last ? FLUSH : STREAM;
        end
      end
      FLUSH: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = DONE;
      end
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        extra_d = 1'b1;
        state_d = DONE;
      end
    endcase
  end

  always_ff @(posedge clk_rwds or posedge resetReadModule) begin
    if (resetReadModule) begin
      state_q    <= SKIP;
      valid_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
      extra_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
      extra_q    <= extra_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign last_o     = last_q;
  assign word_cnt_o = word_cnt;
  assign overflow_o = overflow_q;
  assign extra_o    = extra_q;

endmodule

// File: tb/tb_hyperbus_rx_framer.sv
// Directed bench for hyperbus_rx_framer with hand-computed expectations.
module tb_hyperbus_rx_framer;

  logic        clk_rwds;
  logic        resetReadModule;
  logic [9:0]  burst_len_i;
  logic [1:0]  skip_i;
  logic [15:0] data_i;
  logic        fifo_ready_i;
  logic        valid_o;
  logic [15:0] data_o;
  logic        last_o;
  logic [9:0]  word_cnt_o;
  logic        overflow_o;
  logic        extra_o;

  int unsigned n_checks;
  int unsigned n_fail;

  hyperbus_rx_framer #(.LEN_W(10), .SKIP_W(2)) dut (
    .clk_rwds        (clk_rwds),
    .resetReadModule (resetReadModule),
    .burst_len_i     (burst_len_i),
    .skip_i          (skip_i),
    .data_i          (data_i),
    .fifo_ready_i    (fifo_ready_i),
    .valid_o         (valid_o),
    .data_o          (data_o),
    .last_o          (last_o),
    .word_cnt_o      (word_cnt_o),
    .overflow_o      (overflow_o),
    .extra_o         (extra_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One gated RWDS edge; outputs are sampled afterwards with the clock low.
  task automatic tick(input logic [15:0] d, input logic rdy);
    data_i       = d;
    fifo_ready_i = rdy;
    #5 clk_rwds = 1'b1;
    #5 clk_rwds = 1'b0;
  endtask

  task automatic start_burst(input logic [9:0] len, input logic [1:0] skp);
    resetReadModule = 1'b1;
    burst_len_i     = len;
    skip_i          = skp;
    fifo_ready_i    = 1'b1;
    #5 resetReadModule = 1'b0;
    #5;
  endtask

  task automatic check_word(input string tag, input logic v, input logic [15:0] d,
                            input logic l, input logic [9:0] c);
    check({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v});
    check({tag, ".data"}, {16'd0, data_o}, {16'd0, d});
    check({tag, ".last"}, {31'd0, last_o}, {31'd0, l});
    check({tag, ".cnt"}, {22'd0, word_cnt_o}, {22'd0, c});
  endtask

  task automatic check_flags(input string tag, input logic ov, input logic ex);
    check({tag, ".overflow"}, {31'd0, overflow_o}, {31'd0, ov});
    check({tag, ".extra"}, {31'd0, extra_o}, {31'd0, ex});
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    clk_rwds        = 1'b0;
    resetReadModule = 1'b1;
    burst_len_i     = 10'd4;
    skip_i          = 2'd1;
    data_i          = 16'h0;
    fifo_ready_i    = 1'b1;
    #3;
    check_word("rst", 1'b0, 16'h0, 1'b0, 10'd0);
    check_flags("rst", 1'b0, 1'b0);

    // Nominal, followed by extra edges past the flush edge
    start_burst(10'd4, 2'd1);
    tick(16'h1111, 1'b1); check_word("nom.e1", 1'b0, 16'h0000, 1'b0, 10'd0);
    tick(16'h2222, 1'b1); check_word("nom.e2", 1'b1, 16'h2222, 1'b0, 10'd1);
    tick(16'h3333, 1'b1); check_word("nom.e3", 1'b1, 16'h3333, 1'b0, 10'd2);
    tick(16'h4444, 1'b1); check_word("nom.e4", 1'b1, 16'h4444, 1'b0, 10'd3);
    tick(16'h5555, 1'b1); check_word("nom.e5", 1'b1, 16'h5555, 1'b1, 10'd4);
    tick(16'h6666, 1'b1); check_word("nom.flush", 1'b0, 16'h5555, 1'b0, 10'd4);
    check_flags("nom.flush", 1'b0, 1'b0);
    tick(16'h7777, 1'b1); check_word("ext.e7", 1'b0, 16'h5555, 1'b0, 10'd4);
    check_flags("ext.e7", 1'b0, 1'b1);
    tick(16'h8888, 1'b1);
    tick(16'h9999, 1'b1); check_word("ext.e9", 1'b0, 16'h5555, 1'b0, 10'd4);
    check_flags("ext.e9", 1'b0, 1'b1);

    // Overflow: FIFO not ready on the edge sampling word 3
    start_burst(10'd8, 2'd0);
    for (int k = 1; k <= 8; k++) begin
      tick(16'hA000 + 16'(k), (k == 4) ? 1'b0 : 1'b1);
      check_word($sformatf("ovf.w%0d", k), 1'b1, 16'hA000 + 16'(k), (k == 8), 10'(k));
      check_flags($sformatf("ovf.w%0d", k), (k >= 4), 1'b0);
    end
    tick(16'hFFFF, 1'b1); check_word("ovf.flush", 1'b0, 16'hA008, 1'b0, 10'd8);
    check_flags("ovf.flush", 1'b1, 1'b0);

    // Zero length
    start_burst(10'd0, 2'd0);
    tick(16'h1234, 1'b1); check_word("zero.e1", 1'b0, 16'h0, 1'b0, 10'd0);
    check_flags("zero.e1", 1'b0, 1'b0);
    tick(16'h5678, 1'b1); check_word("zero.e2", 1'b0, 16'h0, 1'b0, 10'd0);
    check_flags("zero.e2", 1'b0, 1'b1);

    // Mid-burst reset, with overflow raised before it
    start_burst(10'd16, 2'd0);
    for (int k = 1; k <= 5; k++) tick(16'hC000 + 16'(k), (k == 3) ? 1'b0 : 1'b1);
    check_word("mid.pre", 1'b1, 16'hC005, 1'b0, 10'd5);
    check_flags("mid.pre", 1'b1, 1'b0);
    resetReadModule = 1'b1;
    #1;
    check_word("mid.rst", 1'b0, 16'h0, 1'b0, 10'd0);
    check_flags("mid.rst", 1'b0, 1'b0);
    burst_len_i = 10'd2;
    #4 resetReadModule = 1'b0;
    #5;
    tick(16'hB001, 1'b1); check_word("mid.w1", 1'b1, 16'hB001, 1'b0, 10'd1);
    tick(16'hB002, 1'b1); check_word("mid.w2", 1'b1, 16'hB002, 1'b1, 10'd2);
    tick(16'hB003, 1'b1); check_word("mid.flush", 1'b0, 16'hB002, 1'b0, 10'd2);
    check_flags("mid.flush", 1'b0, 1'b0);

    // Maximum length with two skipped edges
    start_burst(10'd1023, 2'd2);
    tick(16'hDEAD, 1'b1);
    tick(16'hBEEF, 1'b1); check_word("max.skip", 1'b0, 16'h0, 1'b0, 10'd0);
    for (int k = 1; k <= 1023; k++) begin
      tick(16'(k) ^ 16'h5A5A, 1'b1);
      check_word($sformatf("max.w%0d", k), 1'b1, 16'(k) ^ 16'h5A5A, (k == 1023), 10'(k));
    end
    tick(16'h0000, 1'b1);
    check_word("max.flush", 1'b0, 16'd1023 ^ 16'h5A5A, 1'b0, 10'd1023);
    check_flags("max.flush", 1'b0, 1'b0);
    tick(16'h0000, 1'b1);
    check_word("max.extra", 1'b0, 16'd1023 ^ 16'h5A5A, 1'b0, 10'd1023);
    check_flags("max.extra", 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
